fetch_inst_queue: RTL and testbench
===================================

# fetch_inst_queue

Instruction queue between the fetch stage and decode. It captures each {pc, instruction} pair returned by the I-cache into a small in-order FIFO and presents the oldest entry to decode. It absorbs decode back-pressure and pushes that back-pressure to fetch as a stall. A redirect flush discards all queued instructions in one cycle.

## Interface

Parameters:
- ADDR, `AddrWidth, PC width
- DATA, `DataWidth, instruction width
- DEPTH, 4, number of entries; power of two, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  redirect/flush; discards all entries
- ic_e_  in  1  active-low valid for the I-cache fetch result
- ic_pc  in  ADDR  PC of the fetched instruction
- ic_inst  in  DATA  fetched instruction
- fetch_stall  out  1  queue full; fetch must hold its current request
- dec_e_  out  1  active-low valid; head entry present for decode
- dec_pc  out  ADDR  PC of the head entry
- dec_inst  out  DATA  instruction of the head entry
- dec_busy  in  1  decode cannot accept this cycle

## Operation

- **Storage:** DEPTH entries, each {pc, inst}.
- **Pointers:** write pointer `wp` and read pointer `rp`, each log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: `wp == rp`.
  - Full: index bits equal and wrap bits differ.
  - Pointers increment modulo 2·DEPTH, so they wrap naturally.
- **Count:** `cnt = wp - rp`, computed in log2(DEPTH)+1 bits, range 0..DEPTH.
- **Push:** occurs when `!ic_e_ && !full && !flush`. The entry is written at `wp` and `wp` increments.
- **Pop:** occurs when `!dec_e_ && !dec_busy && !flush`. `rp` increments.
- **Simultaneous push and pop:**
  - Allowed whenever not full and not empty; `cnt` is unchanged.
  - When full, the push is refused even if a pop happens the same cycle. `fetch_stall` is a pure function of the current state.
  - When empty, there is no pop and no bypass. The push completes and the entry appears next cycle.
- **Push while full:** a push with `!ic_e_ && full` is ignored. Fetch is required to hold, because `fetch_stall` was already high.
- **Flush:** `wp` and `rp` clear to 0. Any push or pop in the same cycle is discarded. Storage contents are not cleared.
- **Reset:** identical to flush. Reset has priority over flush.
- **Outputs:**
  - `dec_e_ = empty`
  - `fetch_stall = full`
  - `dec_pc` / `dec_inst` read storage at `rp[idx]`; their value is don't-care while `dec_e_ = 1`.
- **Reset values:** `dec_e_ = 1`, `fetch_stall = 0`, `dec_pc = 0`, `dec_inst = 0`. The storage is reset so that the X-free outputs hold 0.

## Timing

- **Latency:** an entry pushed in cycle N is visible to decode at cycle N+1 (`dec_e_ = 0`). Minimum fetch-to-decode latency is 1 cycle.
- **Throughput:** 1 instruction/cycle in steady state with `dec_busy = 0`.
- **`fetch_stall` assertion:** rises the cycle after the push that fills the queue.
- **`fetch_stall` deassertion:** falls the cycle after the first pop from full.
- **Flush recovery:** in the cycle after a flush, `dec_e_ = 1` and `fetch_stall = 0`. A push is accepted in that same cycle, and decode sees it one cycle later.
- **Ordering:** decode receives entries strictly in push order, with no duplication and no loss except by flush or reset.
- **Combinational paths:** all outputs depend only on registered state. There is no combinational path from `ic_*`, `dec_busy`, or `flush` to any output.

## Structure

- **Shared `fetch.svh` package:**
  - `typedef struct packed {logic [ADDR-1:0] pc; logic [DATA-1:0] inst;} iq_entry_t`
  - constant `IqDepth = 4`
  - the `IqPtrW` derivation
- **Sub-module `fetch_iq_ram`:** DEPTH×entry register file with one write port and one asynchronous read port, synchronously cleared on reset.
- **Top level:** contains the pointer/count logic, full/empty derivation, and handshake gating.

## Test plan

1. **Reset, then single push.** Stimulus: reset; push `pc=0x1000`, `inst=0x00000013`. Required: `dec_e_ = 1` in the push cycle. Next cycle: `dec_e_ = 0`, `dec_pc = 0x1000`, `dec_inst = 0x13`.
2. **Fill and stall with decode held off.** Stimulus: `dec_busy = 1`; push PCs 0x1000, 0x1004, 0x1008, 0x100C. Required: `fetch_stall = 1` after the 4th push. A 5th push (0x1010) held 3 cycles is not written. Releasing `dec_busy` yields 0x1000 … 0x100C in order, then 0x1010 once re-presented.
3. **Streaming through pointer wrap.** Stimulus: continuous push and pop of 20 sequential PCs starting at 0x2000, stride 4. Required: output sequence identical to input, one per cycle after the first, and `fetch_stall` never asserted.
4. **Flush with queue partly full and a push in the same cycle.** Stimulus: 3 entries queued; assert `flush` together with a push of 0x3000. Required: next cycle `dec_e_ = 1`. A push of 0x4000 in that cycle appears alone at decode one cycle later.
5. **Full, with push and pop in the same cycle.** Stimulus: queue full; `dec_busy = 0` and a push of 0x5000 in the same cycle. Required: head pops, 0x5000 is not written, and `fetch_stall` drops next cycle.
6. **Reset mid-stream.** Stimulus: assert `reset` during traffic with 2 entries queued. Required: next cycle all outputs at reset values, and subsequent traffic behaves as in scenario 1.

Source files
------------

// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_inst_queue_pkg;

    localparam int AddrWidth = 32;
    localparam int DataWidth = 32;
    localparam int IqDepth   = 4;

    // Pointers carry one extra wrap bit above the index bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int IqPtrW = ptr_width(IqDepth);

    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [DataWidth-1:0] inst;
    } iq_entry_t;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
interface fetch_inst_queue_if #(
    parameter int ADDR = 32,
    parameter int DATA = 32
);
    logic            flush;
    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [DATA-1:0] ic_inst;
    logic            fetch_stall;
    logic            dec_e_;
    logic [ADDR-1:0] dec_pc;
    logic [DATA-1:0] dec_inst;
    logic            dec_busy;

    modport master (
        output flush, ic_e_, ic_pc, ic_inst, dec_busy,
        input  fetch_stall, dec_e_, dec_pc, dec_inst
    );

    modport slave (
        input  flush, ic_e_, ic_pc, ic_inst, dec_busy,
        output fetch_stall, dec_e_, dec_pc, dec_inst
    );
endinterface

// File: rtl/fetch_iq_ram.sv
// DEPTH x W register file: one write port, one asynchronous read port,
// cleared on reset so the read data is never X.
module fetch_iq_ram #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int IdxW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IdxW-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [IdxW-1:0] raddr,
    output logic [W-1:0]    rdata
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] wsel;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
        assign wsel[gi] = we && (waddr == IdxW'(gi));
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = wsel[i] ? wdata : mem_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_inst_queue.sv
// In-order {pc, inst} FIFO between the I-cache and decode; back-pressure from
// decode becomes fetch_stall, and flush empties the queue in one cycle.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int ADDR  = AddrWidth,
    parameter int DATA  = DataWidth,
    parameter int DEPTH = IqDepth
) (
    input  logic               clk,
    input  logic               reset,
    fetch_inst_queue_if.slave  bus
);
    localparam int IdxW = $clog2(DEPTH);
    localparam int PtrW = ptr_width(DEPTH);
    localparam int EntW = ADDR + DATA;

    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [PtrW-1:0] cnt;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [EntW-1:0] rd_entry;

    // Full/empty come only from registered pointers, so no input reaches an output.
    always_comb begin
        cnt   = wp_q - rp_q;
        empty = (wp_q == rp_q);
        full  = (wp_q[IdxW-1:0] == rp_q[IdxW-1:0]) && (wp_q[IdxW] != rp_q[IdxW]);
        push  = !bus.ic_e_ && !full && !bus.flush;
        pop   = !empty && !bus.dec_busy && !bus.flush;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (bus.flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (push) wp_d = wp_q + PtrW'(1);
            if (pop)  rp_d = rp_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    fetch_iq_ram #(
        .W     (EntW),
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wp_q[IdxW-1:0]),
        .wdata ({bus.ic_pc, bus.ic_inst}),
        .raddr (rp_q[IdxW-1:0]),
        .rdata (rd_entry)
    );

    assign bus.dec_e_      = empty;
    assign bus.fetch_stall = (cnt == PtrW'(DEPTH));
    assign bus.dec_pc      = rd_entry[EntW-1:DATA];
    assign bus.dec_inst    = rd_entry[DATA-1:0];

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Randomized and directed checks of fetch_inst_queue against a queue-based model.
module tb_fetch_inst_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    fetch_inst_queue_if #(.ADDR(32), .DATA(32)) bus ();

    fetch_inst_queue #(.ADDR(32), .DATA(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [63:0] mq[$];
    int total = 0;
    int bad   = 0;

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst);
        bus.ic_e_   = !v;
        bus.ic_pc   = pc;
        bus.ic_inst = inst;
    endtask

    // Model advances from the inputs present before the edge; full is judged pre-pop.
    task automatic tick();
        bit do_push;
        bit do_pop;
        if (reset || bus.flush) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && !bus.dec_busy;
            do_push = !bus.ic_e_ && (mq.size() < DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({bus.ic_pc, bus.ic_inst});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.flush = 1'b0; bus.dec_busy = 1'b0;
        drive(1'b1, 32'hDEAD_0000, 32'hBEEF);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL reset_dec_e got=%b exp=1", bus.dec_e_); end
        total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.fetch_stall); end
        total++; if (bus.dec_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", bus.dec_pc); end
        total++; if (bus.dec_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", bus.dec_inst); end
        drive(1'b1, 32'h1000, 32'h0000_0013);
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL single_push_cycle_dec_e got=%b exp=1", bus.dec_e_); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.dec_e_ !== 1'b0) begin bad++; $display("FAIL single_dec_e got=%b exp=0", bus.dec_e_); end
        total++; if (bus.dec_pc !== 32'h1000) begin bad++; $display("FAIL single_pc got=%h exp=1000", bus.dec_pc); end
        total++; if (bus.dec_inst !== 32'h13) begin bad++; $display("FAIL single_inst got=%h exp=13", bus.dec_inst); end
        tick();
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL single_drain got=%b exp=1", bus.dec_e_); end
        $display("test_reset: done, queue size=%0d", mq.size());
    endtask

    task automatic test_fill_stall();
        bit acc;
        bus.dec_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
            total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL fill_stall_early i=%0d got=%b exp=0", i, bus.fetch_stall); end
            tick();
        end
        drive(1'b1, 32'h1010, 32'h1010);
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.fetch_stall !== 1'b1) begin bad++; $display("FAIL fill_stall c=%0d got=%b exp=1", c, bus.fetch_stall); end
            total++; if (bus.dec_pc !== 32'h1000) begin bad++; $display("FAIL fill_head c=%0d got=%h exp=1000", c, bus.dec_pc); end
            tick();
        end
        bus.dec_busy = 1'b0;
        for (int k = 0; k <= DEPTH; k++) begin
            total++; if (bus.dec_e_ !== 1'b0) begin bad++; $display("FAIL fill_drain_e k=%0d got=%b exp=0", k, bus.dec_e_); end
            total++; if (bus.dec_pc !== 32'h1000 + 32'(4 * k)) begin bad++; $display("FAIL fill_order k=%0d got=%h exp=%h", k, bus.dec_pc, 32'h1000 + 32'(4 * k)); end
            if (k == 1) begin
                total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL fill_stall_fall got=%b exp=0", bus.fetch_stall); end
            end
            acc = !bus.ic_e_ && (mq.size() < DEPTH);
            tick();
            if (acc) drive(1'b0, 32'h0, 32'h0);
        end
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL fill_end_empty got=%b exp=1", bus.dec_e_); end
        $display("test_fill_stall: done, queue size=%0d", mq.size());
    endtask

    task automatic test_stream_wrap();
        bus.dec_busy = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) drive(1'b1, 32'h2000 + 32'(4 * i), 32'hA000 + 32'(i));
            else        drive(1'b0, 32'h0, 32'h0);
            total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL stream_stall i=%0d got=%b exp=0", i, bus.fetch_stall); end
            if (i >= 1) begin
                total++; if (bus.dec_e_ !== 1'b0 || bus.dec_pc !== 32'h2000 + 32'(4 * (i - 1)) || bus.dec_inst !== 32'hA000 + 32'(i - 1))
                begin bad++; $display("FAIL stream_out i=%0d got=%b/%h/%h exp=0/%h/%h", i, bus.dec_e_, bus.dec_pc, bus.dec_inst, 32'h2000 + 32'(4 * (i - 1)), 32'hA000 + 32'(i - 1)); end
            end
            tick();
        end
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL stream_end got=%b exp=1", bus.dec_e_); end
        $display("test_stream_wrap: done, 20 entries streamed");
    endtask

    task automatic test_flush();
        bus.dec_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3100 + 32'(4 * i), 32'h31);
            tick();
        end
        bus.flush = 1'b1;
        drive(1'b1, 32'h3000, 32'h30);
        tick();
        bus.flush = 1'b0;
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL flush_dec_e got=%b exp=1", bus.dec_e_); end
        total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.fetch_stall); end
        drive(1'b1, 32'h4000, 32'h40);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.dec_e_ !== 1'b0 || bus.dec_pc !== 32'h4000) begin bad++; $display("FAIL flush_recover got=%b/%h exp=0/4000", bus.dec_e_, bus.dec_pc); end
        bus.dec_busy = 1'b0;
        tick();
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL flush_alone got=%b exp=1", bus.dec_e_); end
        $display("test_flush: done, queue size=%0d", mq.size());
    endtask

    task automatic test_full_push_pop();
        bus.dec_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h5100 + 32'(4 * i), 32'h51);
            tick();
        end
        total++; if (bus.fetch_stall !== 1'b1) begin bad++; $display("FAIL fullpp_stall got=%b exp=1", bus.fetch_stall); end
        bus.dec_busy = 1'b0;
        drive(1'b1, 32'h5000, 32'h50);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        bus.dec_busy = 1'b1;
        total++; if (bus.fetch_stall !== 1'b0) begin bad++; $display("FAIL fullpp_stall_fall got=%b exp=0", bus.fetch_stall); end
        bus.dec_busy = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            total++; if (bus.dec_e_ !== 1'b0 || bus.dec_pc !== 32'h5100 + 32'(4 * k)) begin bad++; $display("FAIL fullpp_order k=%0d got=%b/%h exp=0/%h", k, bus.dec_e_, bus.dec_pc, 32'h5100 + 32'(4 * k)); end
            tick();
        end
        total++; if (bus.dec_e_ !== 1'b1) begin bad++; $display("FAIL fullpp_refused got=%b/%h exp=1", bus.dec_e_, bus.dec_pc); end
        $display("test_full_push_pop: done, queue size=%0d", mq.size());
    endtask

    task automatic test_reset_midstream();
        bus.dec_busy = 1'b1;
        drive(1'b1, 32'h6000, 32'h60); tick();
        drive(1'b1, 32'h6004, 32'h61); tick();
        drive(1'b1, 32'h6008, 32'h62);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus.dec_busy = 1'b0;
        total++; if (bus.dec_e_ !== 1'b1 || bus.fetch_stall !== 1'b0 || bus.dec_pc !== 32'h0 || bus.dec_inst !== 32'h0)
        begin bad++; $display("FAIL midreset_outputs got=%b/%b/%h/%h exp=1/0/0/0", bus.dec_e_, bus.fetch_stall, bus.dec_pc, bus.dec_inst); end
        drive(1'b1, 32'h1000, 32'h13);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.dec_e_ !== 1'b0 || bus.dec_pc !== 32'h1000 || bus.dec_inst !== 32'h13)
        begin bad++; $display("FAIL midreset_push got=%b/%h/%h exp=0/1000/13", bus.dec_e_, bus.dec_pc, bus.dec_inst); end
        tick();
        $display("test_reset_midstream: done, queue size=%0d", mq.size());
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom);
            bus.dec_busy = ($urandom_range(0, 2) == 0);
            bus.flush    = ($urandom_range(0, 29) == 0);
            reset        = ($urandom_range(0, 99) == 0);
            total++; if (bus.dec_e_ !== (mq.size() == 0)) begin bad++; $display("FAIL rand_dec_e c=%0d got=%b exp=%b", c, bus.dec_e_, mq.size() == 0); end
            total++; if (bus.fetch_stall !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, bus.fetch_stall, mq.size() == DEPTH); end
            if (mq.size() > 0) begin
                total++; if ({bus.dec_pc, bus.dec_inst} !== mq[0]) begin bad++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, {bus.dec_pc, bus.dec_inst}, mq[0]); end
            end
            tick();
        end
        reset = 1'b0; bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        $display("test_random: done, 400 cycles, queue size=%0d", mq.size());
    endtask

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.dec_busy = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        test_reset();
        test_fill_stall();
        test_stream_wrap();
        test_flush();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
